// File: rtl/vga_pixel_streamer.sv
// -----------------------------------------------------------------------------
// vga_pixel_streamer
//
// Sits between the address_generator and a valid/ready VGA video sink.
// Every cycle with ag_ready=1 issues one frame-buffer address.  The
// start/end flags that came with that address travel down a RD_LAT-deep
// pipe so they meet the returning ram_q word.  The pixel is expanded from
// RGB444 to RGB101010 and pushed into a small show-ahead FIFO that drives
// the sink.  ag_ready is a credit: an address is only issued when a FIFO
// slot is guaranteed for its data, so sink backpressure never loses pixels.
//
// Ports
//   clk_25_vga  in   pixel clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ag_start    in   packet start flag, aligned with the presented address
//   ag_end      in   packet end flag, aligned with the presented address
//   ag_ready    out  address presented this cycle is issued
//   ram_q       in   {R,G,B} 4 bits each, valid RD_LAT cycles after issue
//   vid_data    out  {R,G,B} 10 bits each
//   vid_valid   out  vid_* holds a pixel
//   vid_sop     out  first pixel of packet
//   vid_eop     out  last pixel of packet
//   vid_ready   in   sink accepts on vid_valid & vid_ready
//   frame_err   out  sticky packet-length / framing error
//
// Optional feature: define VGA_STREAMER_CHECK_EN to build the packet-length
// checker that drives frame_err; otherwise frame_err is tied low.
// -----------------------------------------------------------------------------
module vga_pixel_streamer #(
  parameter int RD_LAT       = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic        clk_25_vga,
  input  logic        rst_n,
  input  logic        ag_start,
  input  logic        ag_end,
  output logic        ag_ready,
  input  logic [11:0] ram_q,
  output logic [29:0] vid_data,
  output logic        vid_valid,
  output logic        vid_sop,
  output logic        vid_eop,
  input  logic        vid_ready,
  output logic        frame_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CW + 1;

  // Elaboration-time parameter sanity.
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("vga_pixel_streamer: RD_LAT must be 1..3");
  end
  if (FIFO_DEPTH < RD_LAT + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vga_pixel_streamer: FIFO_DEPTH must be a power of 2 and >= RD_LAT+1");
  end
  if (FRAME_PIXELS < 1) begin : g_bad_frame
    $error("vga_pixel_streamer: FRAME_PIXELS must be positive");
  end

  typedef struct packed {
    logic [29:0] data;
    logic        sop;
    logic        eop;
  } pix_t;

  // 4-bit channel to 10 bits by bit replication: full scale maps to full scale.
  function automatic logic [9:0] expand(input logic [3:0] c);
    return {c, c, c[3:2]};
  endfunction

  // ---------------------------------------------------------------------------
  // Flag pipe: tracks which cycles carry an issued read and its packet flags.
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0] vld_pipe_q, sop_pipe_q, eop_pipe_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  occ;
  logic              issue, push, pop;
  pix_t              push_pix, head;
  pix_t              mem_q [FIFO_DEPTH];

  // Credit check: occupied slots plus reads already on their way must leave
  // room for the one being issued now.  Driven from registered counts only.
  always_comb begin
    occ      = {1'b0, count_q} + {1'b0, inflight_q};
    ag_ready = rst_n & (occ < OCC_W'(FIFO_DEPTH));
  end

  assign issue = ag_ready;
  assign push  = vld_pipe_q[RD_LAT-1];
  assign pop   = vid_valid & vid_ready;

  always_comb begin
    push_pix.data = {expand(ram_q[11:8]), expand(ram_q[7:4]), expand(ram_q[3:0])};
    push_pix.sop  = sop_pipe_q[RD_LAT-1];
    push_pix.eop  = eop_pipe_q[RD_LAT-1];
  end

  always_comb begin
    inflight_d = inflight_q + CW'(issue) - CW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_25_vga or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      sop_pipe_q <= '0;
      eop_pipe_q <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      sop_pipe_q[0] <= issue & ag_start;
      eop_pipe_q[0] <= issue & ag_end;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        sop_pipe_q[i] <= sop_pipe_q[i-1];
        eop_pipe_q[i] <= eop_pipe_q[i-1];
      end
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset: the pointers/count decide what is visible.
  // A push into a full FIFO cannot happen; the credit rule forbids it.
  always_ff @(posedge clk_25_vga) begin
    if (push) mem_q[wr_ptr_q] <= push_pix;
  end

  // ---------------------------------------------------------------------------
  // Show-ahead output.  Head fields are masked so an empty FIFO (and reset)
  // presents all-zero outputs rather than stale storage.
  // ---------------------------------------------------------------------------
  assign head      = mem_q[rd_ptr_q];
  assign vid_valid = (count_q != '0);
  assign vid_data  = vid_valid ? head.data : 30'd0;
  assign vid_sop   = vid_valid & head.sop;
  assign vid_eop   = vid_valid & head.eop;

  // ---------------------------------------------------------------------------
  // Packet-length checker.
  // ---------------------------------------------------------------------------
`ifdef VGA_STREAMER_CHECK_EN
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic        pkt_open_q, err_q;

  // An accepted SOP restarts the count at this pixel.
  assign pix_cnt_d = vid_sop ? 32'd1 : pix_cnt_q + 32'd1;

  always_ff @(posedge clk_25_vga or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q  <= '0;
      pkt_open_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (pop) begin
      pix_cnt_q <= pix_cnt_d;
      if (vid_sop && pkt_open_q)                         err_q <= 1'b1;
      if (vid_eop && pix_cnt_d != 32'(FRAME_PIXELS))     err_q <= 1'b1;
      if (vid_sop)      pkt_open_q <= ~vid_eop;
      else if (vid_eop) pkt_open_q <= 1'b0;
    end
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_pixel_streamer.sv
`timescale 1ns/1ps
module tb_vga_pixel_streamer;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 1000;
`ifdef VGA_STREAMER_CHECK_EN
  localparam logic EXP_SHORT_ERR = 1'b1;
`else
  localparam logic EXP_SHORT_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ag_start = 1'b0, ag_end = 1'b0, vid_ready = 1'b0;
  logic [11:0] ram_q = 12'h000;
  logic        ag_ready, vid_valid, vid_sop, vid_eop, frame_err;
  logic [29:0] vid_data;

  always #5 clk = ~clk;

  vga_pixel_streamer #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_PIXELS(FRAME)) dut (
    .clk_25_vga(clk), .rst_n(rst_n), .ag_start(ag_start), .ag_end(ag_end),
    .ag_ready(ag_ready), .ram_q(ram_q), .vid_data(vid_data), .vid_valid(vid_valid),
    .vid_sop(vid_sop), .vid_eop(vid_eop), .vid_ready(vid_ready), .frame_err(frame_err)
  );

  typedef struct packed { logic [11:0] q; logic sop; logic eop; logic [29:0] exp; } src_t;
  typedef struct packed { logic [29:0] data; logic sop; logic eop; } exp_t;

  src_t src_q[$];
  exp_t exp_q[$];
  int   chk = 0, pass_n = 0;
  int   cyc = 0;
  int   rdy_mode = 0;            // 0: ready=1, 1: ready=0, 2: random
  logic [11:0] fill_d = 12'h000;
  logic [11:0] hist [RD_LAT+1];
  int   sop_issue_cyc = -1, sop_out_cyc = -1, eop_out_cyc = -1, n_eop = 0;
  src_t drv_it;
  exp_t drv_e, mon_e;
  logic held = 1'b0;
  logic [31:0] held_v = '0;

  function automatic logic [29:0] exp30(input logic [11:0] q);
    return {q[11:8], q[11:8], q[11:10], q[7:4], q[7:4], q[7:6], q[3:0], q[3:0], q[3:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_src(input logic [11:0] q, input logic s, input logic e, input logic [29:0] x);
    src_t it;
    it.q = q; it.sop = s; it.eop = e; it.exp = x;
    src_q.push_back(it);
  endtask

  task automatic wait_eop(input int target, input int budget);
    int n = 0;
    while (n_eop < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n_eop < target) begin
      chk++;
      $display("FAIL wait_eop_timeout: got %0d eops want %0d", n_eop, target);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream model: address generator + frame buffer.  Every cycle the
  // presented item issues if ag_ready is high; the expected output is queued
  // and the data is returned on ram_q RD_LAT cycles later.
  always @(posedge clk) begin
    #1;
    if (src_q.size() != 0) drv_it = src_q[0];
    else begin
      drv_it.q = fill_d; drv_it.sop = 1'b0; drv_it.eop = 1'b0; drv_it.exp = exp30(fill_d);
    end
    ag_start = drv_it.sop;
    ag_end   = drv_it.eop;
    for (int i = RD_LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = 12'h000;
    if (ag_ready) begin
      if (src_q.size() != 0) void'(src_q.pop_front());
      else fill_d = fill_d + 12'd37;
      drv_e.data = drv_it.exp; drv_e.sop = drv_it.sop; drv_e.eop = drv_it.eop;
      exp_q.push_back(drv_e);
      hist[0] = drv_it.q;
      if (drv_it.sop) sop_issue_cyc = cyc;
    end
    ram_q = hist[RD_LAT];
    case (rdy_mode)
      0:       vid_ready = 1'b1;
      1:       vid_ready = 1'b0;
      default: vid_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Monitor: pop and compare on every accepted pixel; also check stalled
  // outputs hold their value.
  always @(negedge clk) begin
    if (held && rst_n && vid_valid)
      check("hold_stable", {vid_data, vid_sop, vid_eop}, held_v);
    held   = rst_n & vid_valid & ~vid_ready;
    held_v = {vid_data, vid_sop, vid_eop};
    if (rst_n && vid_valid && vid_ready) begin
      if (exp_q.size() == 0) begin
        chk++;
        $display("FAIL unexpected_pixel: got %0h want none", vid_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", {vid_data, vid_sop, vid_eop}, {mon_e.data, mon_e.sop, mon_e.eop});
      end
      if (vid_sop) sop_out_cyc = cyc;
      if (vid_eop) begin eop_out_cyc = cyc; n_eop++; end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int i = 0; i <= RD_LAT; i++) hist[i] = 12'h000;
    #1 rst_n = 1'b0;
    // Reset: a 1-pixel packet is presented with ag_start=1 throughout.
    push_src(12'h0F0, 1'b1, 1'b1, 30'h000FFC00);
    repeat (5) begin
      @(negedge clk);
      check("rst_ag_ready", {31'd0, ag_ready}, 32'd0);
      check("rst_vid_valid", {31'd0, vid_valid}, 32'd0);
    end
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk); #0.5 rst_n = 1'b1;
    @(negedge clk);
    check("ag_ready_after_rst", {31'd0, ag_ready}, 32'd1);
    wait_eop(1, 50);

    // Stream: 10-pixel packet, latency and back-to-back output.
    t0 = n_eop;
    for (int i = 0; i < 10; i++) push_src(12'h100 + 12'(i), i == 0, i == 9, exp30(12'h100 + 12'(i)));
    wait_eop(t0 + 1, 100);
    check("sop_latency", 32'(sop_out_cyc - sop_issue_cyc), 32'(RD_LAT + 1));
    check("ten_in_ten", 32'(eop_out_cyc - sop_out_cyc), 32'd9);

    // Colour expansion with hand-computed values.
    t0 = n_eop;
    push_src(12'hF80, 1'b1, 1'b0, 30'h3FF88800);
    push_src(12'h5A0, 1'b0, 1'b1, 30'h155AA800);
    wait_eop(t0 + 1, 100);

    // Backpressure: 12 stalled cycles fill the buffer and drop the credit.
    t0 = n_eop;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) push_src(12'h300 + 12'(i), i == 0, i == 7, exp30(12'h300 + 12'(i)));
    repeat (12) @(negedge clk);
    #1;
    check("bp_ag_ready", {31'd0, ag_ready}, 32'd0);
    check("bp_vid_valid", {31'd0, vid_valid}, 32'd1);
    rdy_mode = 0;
    wait_eop(t0 + 1, 200);

    // Reset mid-frame with data buffered: everything in flight is discarded.
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) push_src(12'h400 + 12'(i), i == 0, 1'b0, exp30(12'h400 + 12'(i)));
    repeat (4) @(negedge clk);
    check("pre_rst_valid", {31'd0, vid_valid}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    src_q.delete();
    #1;
    check("midrst_vid_valid", {31'd0, vid_valid}, 32'd0);
    check("midrst_ag_ready", {31'd0, ag_ready}, 32'd0);
    repeat (2) @(posedge clk);
    rdy_mode = 0;
    #0.5 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_frame_err", {31'd0, frame_err}, 32'd0);

    // Full frame with random sink readiness.
    t0 = n_eop;
    rdy_mode = 2;
    for (int i = 0; i < FRAME; i++)
      push_src(12'(i * 7 + 3), i == 0, i == FRAME - 1, exp30(12'(i * 7 + 3)));
    wait_eop(t0 + 1, 20 * FRAME);
    check("frame_err_full", {31'd0, frame_err}, 32'd0);

    // Short packet: end after 100 pixels.
    t0 = n_eop;
    rdy_mode = 0;
    for (int i = 0; i < 100; i++)
      push_src(12'h800 + 12'(i), i == 0, i == 99, exp30(12'h800 + 12'(i)));
    wait_eop(t0 + 1, 500);
    @(negedge clk);
    check("frame_err_short", {31'd0, frame_err}, {31'd0, EXP_SHORT_ERR});

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, chk);
    $finish;
  end
endmodule
